// File: rtl/my_fifo.sv
// Single-clock ready/valid FIFO, first-word-fall-through, optional empty bypass (C_BYPASS).
// Define MY_FIFO_CLEAR_DATA_EN to force read_data to zero whenever read_valid is low.
module my_fifo #(
   parameter int C_DATA_WIDTH = 8,
   parameter int C_FIFO_DEPTH = 1,
   parameter int C_BYPASS     = 0
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    write_valid,
   output logic                    write_ready,
   input  logic [C_DATA_WIDTH-1:0] write_data,
   output logic                    read_valid,
   input  logic                    read_ready,
   output logic [C_DATA_WIDTH-1:0] read_data,
   output logic                    full,
   output logic                    empty
);

   localparam int C_PTR_W = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
   localparam int C_CNT_W = $clog2(C_FIFO_DEPTH + 1);
   localparam logic [C_CNT_W-1:0] C_CNT_MAX  = C_CNT_W'(C_FIFO_DEPTH);
   localparam logic [C_PTR_W-1:0] C_PTR_LAST = C_PTR_W'(C_FIFO_DEPTH - 1);

   logic [C_DATA_WIDTH-1:0] r_mem [C_FIFO_DEPTH];
   logic [C_PTR_W-1:0]      r_wr_ptr;
   logic [C_PTR_W-1:0]      r_rd_ptr;
   logic [C_CNT_W-1:0]      r_count;

   logic                    w_bypass_act;
   logic                    w_wr_commit;
   logic                    w_rd_commit;
   logic                    w_push;
   logic                    w_pop;
   logic [C_DATA_WIDTH-1:0] w_head;

   assign empty        = (r_count == '0);
   assign full         = (r_count == C_CNT_MAX);
   assign w_bypass_act = (C_BYPASS != 0) && empty;
   assign write_ready  = !full && !resetn;
   assign read_valid   = resetn ? 1'b0 : (w_bypass_act ? write_valid : !empty);
   assign w_head       = w_bypass_act ? write_data : r_mem[r_rd_ptr];

`ifdef MY_FIFO_CLEAR_DATA_EN
   assign read_data = read_valid ? w_head : '0;
`else
   assign read_data = w_head;
`endif

   assign w_wr_commit = write_valid && write_ready;
   assign w_rd_commit = read_valid && read_ready;
   // A bypassed word is consumed in the same cycle, so it never touches storage.
   assign w_push      = w_wr_commit && !(w_bypass_act && w_rd_commit);
   assign w_pop       = w_rd_commit && !w_bypass_act;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= write_data;
      end
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == C_PTR_LAST) ? '0 : r_wr_ptr + C_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == C_PTR_LAST) ? '0 : r_rd_ptr + C_PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_CNT_W'(1);
            2'b01:   r_count <= r_count - C_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_my_fifo.sv
// Randomized and directed checks of four my_fifo configurations against a queue model.
module tb_my_fifo;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic       wv_i [4];
   logic       rr_i [4];
   logic [7:0] wd_i [4];
   logic       wr_o [4];
   logic       rv_o [4];
   logic [7:0] rd_o [4];
   logic       full_o [4];
   logic       empty_o [4];

   int depth_a [4];
   bit byp_a [4];
   logic [7:0] model [$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   my_fifo #(.C_DATA_WIDTH(8), .C_FIFO_DEPTH(1), .C_BYPASS(0)) u_d0 (
      .clk(clk), .resetn(resetn), .write_valid(wv_i[0]), .write_ready(wr_o[0]),
      .write_data(wd_i[0]), .read_valid(rv_o[0]), .read_ready(rr_i[0]),
      .read_data(rd_o[0]), .full(full_o[0]), .empty(empty_o[0]));
   my_fifo #(.C_DATA_WIDTH(8), .C_FIFO_DEPTH(4), .C_BYPASS(0)) u_d1 (
      .clk(clk), .resetn(resetn), .write_valid(wv_i[1]), .write_ready(wr_o[1]),
      .write_data(wd_i[1]), .read_valid(rv_o[1]), .read_ready(rr_i[1]),
      .read_data(rd_o[1]), .full(full_o[1]), .empty(empty_o[1]));
   my_fifo #(.C_DATA_WIDTH(8), .C_FIFO_DEPTH(3), .C_BYPASS(0)) u_d2 (
      .clk(clk), .resetn(resetn), .write_valid(wv_i[2]), .write_ready(wr_o[2]),
      .write_data(wd_i[2]), .read_valid(rv_o[2]), .read_ready(rr_i[2]),
      .read_data(rd_o[2]), .full(full_o[2]), .empty(empty_o[2]));
   my_fifo #(.C_DATA_WIDTH(8), .C_FIFO_DEPTH(2), .C_BYPASS(1)) u_d3 (
      .clk(clk), .resetn(resetn), .write_valid(wv_i[3]), .write_ready(wr_o[3]),
      .write_data(wd_i[3]), .read_valid(rv_o[3]), .read_ready(rr_i[3]),
      .read_data(rd_o[3]), .full(full_o[3]), .empty(empty_o[3]));

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input int k, input string what);
      check($sformatf("d%0d %s empty", k, what), {7'd0, empty_o[k]}, 8'd1);
      check($sformatf("d%0d %s full", k, what), {7'd0, full_o[k]}, 8'd0);
      check($sformatf("d%0d %s read_valid", k, what), {7'd0, rv_o[k]}, 8'd0);
      check($sformatf("d%0d %s write_ready", k, what), {7'd0, wr_o[k]}, 8'd0);
   endtask

   // One clock cycle on DUT k: drive, compare outputs with the queue model, then advance it.
   task automatic step(input int k, input logic wv, input logic [7:0] d, input logic rr);
      int n;
      logic e_empty, e_full, e_wr, e_rv, wc, rc;
      logic [7:0] e_rd;
      @(posedge clk);
      #1;
      wv_i[k] = wv;
      wd_i[k] = d;
      rr_i[k] = rr;
      #1;
      n       = model.size();
      e_empty = (n == 0);
      e_full  = (n == depth_a[k]);
      e_wr    = !e_full;
      e_rv    = (n > 0) || (byp_a[k] && wv);
      e_rd    = (n > 0) ? model[0] : d;
      check($sformatf("d%0d empty", k), {7'd0, empty_o[k]}, {7'd0, e_empty});
      check($sformatf("d%0d full", k), {7'd0, full_o[k]}, {7'd0, e_full});
      check($sformatf("d%0d write_ready", k), {7'd0, wr_o[k]}, {7'd0, e_wr});
      check($sformatf("d%0d read_valid", k), {7'd0, rv_o[k]}, {7'd0, e_rv});
      if (e_rv) check($sformatf("d%0d read_data", k), rd_o[k], e_rd);
      $display("d%0d wv=%0b wd=%02h rr=%0b occ=%0d rv=%0b rd=%02h", k, wv, d, rr, n, rv_o[k], rd_o[k]);
      wc = wv && e_wr;
      rc = e_rv && rr;
      if (!(n == 0 && rc)) begin
         if (rc) void'(model.pop_front());
         if (wc) model.push_back(d);
      end
   endtask

   task automatic finish_dut(input int k);
      @(posedge clk);
      #1;
      wv_i[k] = 1'b0;
      rr_i[k] = 1'b0;
      model.delete();
   endtask

   task automatic random_run(input int k, input int n, input int wbias, input int rbias);
      for (int i = 0; i < n; i++) begin
         step(k, $urandom_range(0, 99) < wbias, 8'($urandom), $urandom_range(0, 99) < rbias);
      end
   endtask

   initial begin
      depth_a = '{1, 4, 3, 2};
      byp_a   = '{0, 0, 0, 1};
      for (int k = 0; k < 4; k++) begin
         wv_i[k] = 1'b0;
         rr_i[k] = 1'b0;
         wd_i[k] = 8'h00;
      end

      // Reset held high: flags at reset values.
      repeat (2) @(posedge clk);
      #2;
      for (int k = 0; k < 4; k++) check_idle(k, "in reset");
      resetn = 1'b0;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++)
         check($sformatf("d%0d write_ready after release", k), {7'd0, wr_o[k]}, 8'd1);

      // Depth 1, no bypass.
      step(0, 1'b1, "a", 1'b1);
      step(0, 1'b1, "b", 1'b0);
      step(0, 1'b1, "b", 1'b1);
      step(0, 1'b1, "b", 1'b1);
      step(0, 1'b1, "c", 1'b1);
      step(0, 1'b1, "c", 1'b1);
      step(0, 1'b1, "d", 1'b1);
      step(0, 1'b1, "d", 1'b1);
      step(0, 1'b0, 8'h00, 1'b1);
      random_run(0, 40, 60, 60);
      finish_dut(0);

      // Depth 4: fill, stall, drain, twice for pointer wrap.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 5; i++) step(1, 1'b1, 8'("a" + i), 1'b0);
         for (int i = 0; i < 5; i++) step(1, 1'b0, 8'h00, 1'b1);
      end
      random_run(1, 40, 60, 50);
      for (int i = 0; i < 3; i++) step(1, 1'b1, 8'(8'h30 + i), 1'b0);

      // Asynchronous reset away from any clock edge.
      @(posedge clk);
      #3;
      resetn = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) check_idle(k, "async reset");
      model.delete();
      wv_i[1] = 1'b0;
      rr_i[1] = 1'b0;
      #1;
      resetn = 1'b0;

      // Depth 3, non-power-of-two.
      for (int i = 0; i < 10; i++) step(2, 1'b1, 8'(8'h10 + i), i[0]);
      random_run(2, 40, 70, 40);
      finish_dut(2);

      // Depth 2 with bypass.
      step(3, 1'b1, "x", 1'b1);
      step(3, 1'b0, 8'h00, 1'b0);
      step(3, 1'b1, "y", 1'b0);
      step(3, 1'b1, "z", 1'b1);
      step(3, 1'b0, 8'h00, 1'b1);
      step(3, 1'b0, 8'h00, 1'b0);
      random_run(3, 40, 50, 50);
      finish_dut(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
